// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD issue queue.
// The optional statistics counters are enabled with GCD_ISSUE_STATS_EN.
package gcd_pkg;

  localparam int unsigned GCD_W = 16;

  typedef enum logic {
    READY = 1'b0,
    BUSY  = 1'b1
  } issue_state_t;

  typedef struct packed {
    logic [GCD_W-1:0] A;
    logic [GCD_W-1:0] B;
  } gcd_operands_t;

endpackage

// File: rtl/gcd_issue_fifo.sv
// Synchronous FIFO holding operand pairs for the GCD issue queue.
// Pointers wrap modulo DEPTH (a power of two); count ranges 0..DEPTH.
module gcd_issue_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: reset empties the FIFO through the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/gcd_issue_queue.sv
// Buffers operand pairs and issues them one at a time to an idle GCD unit.
// Define GCD_ISSUE_STATS_EN to add the issued_count/completed_count outputs.
module gcd_issue_queue
  import gcd_pkg::*;
#(
  parameter int unsigned W     = GCD_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_bits_A,
  input  logic [W-1:0]           in_bits_B,
  output logic                   data_rdy,
  output logic [W-1:0]           operands_bits_A,
  output logic [W-1:0]           operands_bits_B,
  input  logic                   result_rdy,
  input  logic                   result_taken,
  output logic                   gcd_busy,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef GCD_ISSUE_STATS_EN
  ,
  output logic [31:0]            issued_count,
  output logic [31:0]            completed_count
`endif
);

  typedef struct packed {
    logic [W-1:0] A;
    logic [W-1:0] B;
  } entry_t;

  issue_state_t state;
  issue_state_t state_next;
  entry_t       push_entry;
  entry_t       head;
  logic         full;
  logic         empty;
  logic         issue;
  logic         take;

  assign push_entry = '{A: in_bits_A, B: in_bits_B};
  assign in_ready   = !full;
  assign gcd_busy   = (state == BUSY);
  assign take       = (state == BUSY) && result_rdy && result_taken;

  gcd_issue_fifo #(
    .WIDTH(2 * W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (in_valid),
    .push_data(push_entry),
    .pop      (issue),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (fifo_count)
  );

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      READY: begin
        if (!empty) begin
          issue      = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (take) state_next = READY;
      end
      default: state_next = READY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= READY;
      data_rdy        <= 1'b0;
      operands_bits_A <= '0;
      operands_bits_B <= '0;
    end else begin
      state    <= state_next;
      data_rdy <= issue;
      // Operands hold the last issued pair between strobes.
      if (issue) begin
        operands_bits_A <= head.A;
        operands_bits_B <= head.B;
      end
    end
  end

`ifdef GCD_ISSUE_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issued_count    <= '0;
      completed_count <= '0;
    end else begin
      if (issue) issued_count    <= issued_count + 32'd1;
      if (take)  completed_count <= completed_count + 32'd1;
    end
  end
`endif

endmodule
